// File: rtl/data_memory_sized.sv
// Word-organised MEM-stage data memory with a valid/ready request/response handshake.
// Byte/half/word access, sign/zero extension, alignment and range checking.
module data_memory_sized #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDRESS_WIDTH = 20,
  parameter int    MEM_SIZE      = 8192,
  parameter int    READ_LATENCY  = 2,
  parameter string INIT_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_err
);

  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       armed_q;

  logic            we_q, err_q, uns_q;
  logic [1:0]      size_q, off_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic            accept, req_err;
  logic            bad_size, misalign, out_of_range;
  logic            wr_en, rd_en;
  logic [3:0]      be;
  logic [DATA_WIDTH-1:0] wlanes;
  logic [IW-1:0]   word_idx;

  assign accept   = req_valid & req_ready;
  assign word_idx = address[IW+1:2];

  always_comb begin
    bad_size     = (req_size == 2'b11);
    misalign     = ((req_size == 2'b01) && address[0])
                || ((req_size == 2'b10) && (address[1:0] != 2'b00));
    out_of_range = 32'(address[ADDRESS_WIDTH-1:2]) >= 32'(MEM_SIZE);
    req_err      = bad_size | misalign | out_of_range;
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = write_data;
    unique case (req_size)
      2'b00: begin
        be     = 4'b0001 << address[1:0];
        wlanes = {4{write_data[7:0]}};
      end
      2'b01: begin
        be     = address[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{write_data[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wr_en = accept & req_we & ~req_err;
  assign rd_en = accept & ~req_we & ~req_err;

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
    if (rd_en) rd_q <= mem[word_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
      if (accept) begin
        we_q   <= req_we;
        err_q  <= req_err;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        off_q  <= address[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (req_we || req_err || (READ_LATENCY == 1)) state_d = RESP;
          else                                          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'(READ_LATENCY - 2)) state_d = RESP;
        else                               cnt_d   = cnt_q + 2'd1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] shifted, load_fmt;

  always_comb begin
    shifted  = rd_q >> {off_q, 3'b000};
    load_fmt = rd_q;
    unique case (size_q)
      2'b00: load_fmt = uns_q ? {24'b0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_fmt = uns_q ? {16'b0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      default: load_fmt = rd_q;
    endcase
  end

  assign req_ready  = armed_q && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (resp_valid && !we_q && !err_q) ? load_fmt : '0;

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: vector table with scoreboard,
// plus stall, reset-in-WAIT and reset-in-RESP sequences.
module tb_data_memory_sized;

  localparam int MS = 8192;
  localparam int L  = 2;
  localparam logic [19:0] OOR = 20'(4 * MS);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [19:0] address = '0;
  logic [31:0] write_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  data_memory_sized #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(20), .MEM_SIZE(MS),
    .READ_LATENCY(L), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .address(address),
    .write_data(write_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [19:0] addr;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    address      = v.addr;
    write_data   = v.wd;
    sb.push_back('{v.ed, v.ee});
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      check({nm, " sb"}, 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    check({nm, " data"}, resp_data, e.d);
    check({nm, " err"}, 32'(resp_err), 32'(e.e));
  endtask

  task automatic txn(input vec_t v, input string nm);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " ready"}, 32'(req_ready), 1);
    drive(v);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    check({nm, " lat"}, 32'(lat), (v.we || v.ee) ? 32'd1 : 32'(L));
    pop_check(nm);
    @(posedge clk); #1;
    check({nm, " done"}, 32'(resp_valid), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    vec_t v;
    logic [31:0] held;

    tv.push_back('{1, 2'b10, 0, 20'h00018, 32'hB6A84325, 32'h0, 0});
    tv.push_back('{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A84325, 0});
    tv.push_back('{1, 2'b00, 0, 20'h00019, 32'hAAAAAA74, 32'h0, 0});
    tv.push_back('{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A87425, 0});
    tv.push_back('{0, 2'b00, 0, 20'h0001B, 32'h0, 32'hFFFFFFB6, 0});
    tv.push_back('{0, 2'b00, 1, 20'h0001B, 32'h0, 32'h000000B6, 0});
    tv.push_back('{0, 2'b01, 0, 20'h0001A, 32'h0, 32'hFFFFB6A8, 0});
    tv.push_back('{0, 2'b01, 1, 20'h0001A, 32'h0, 32'h0000B6A8, 0});
    tv.push_back('{0, 2'b01, 0, 20'h00019, 32'h0, 32'h0, 1});
    tv.push_back('{1, 2'b10, 0, OOR, 32'hFFFFFFFF, 32'h0, 1});
    tv.push_back('{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A87425, 0});
    tv.push_back('{0, 2'b11, 0, 20'h00018, 32'h0, 32'h0, 1});
    tv.push_back('{1, 2'b10, 0, 20'h0001A, 32'h12345678, 32'h0, 1});
    tv.push_back('{1, 2'b01, 0, 20'h00019, 32'h12345678, 32'h0, 1});
    tv.push_back('{0, 2'b10, 0, 20'h0001B, 32'h0, 32'h0, 1});
    tv.push_back('{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A87425, 0});
    tv.push_back('{1, 2'b01, 0, 20'h0001E, 32'h1234CAFE, 32'h0, 0});
    tv.push_back('{0, 2'b10, 0, 20'h0001C, 32'h0, 32'hCAFE0000, 0});
    tv.push_back('{0, 2'b01, 0, 20'h0001E, 32'h0, 32'hFFFFCAFE, 0});
    tv.push_back('{1, 2'b00, 0, 20'h0001D, 32'h55555599, 32'h0, 0});
    tv.push_back('{0, 2'b10, 0, 20'h0001C, 32'h0, 32'hCAFE9900, 0});
    tv.push_back('{0, 2'b00, 0, 20'h00018, 32'h0, 32'h00000025, 0});
    tv.push_back('{0, 2'b00, 0, 20'h0001A, 32'h0, 32'hFFFFFFA8, 0});
    tv.push_back('{0, 2'b00, 1, 20'h00019, 32'h0, 32'h00000074, 0});
    tv.push_back('{1, 2'b10, 0, 20'h07FFC, 32'h11223344, 32'h0, 0});
    tv.push_back('{0, 2'b10, 0, 20'h07FFC, 32'h0, 32'h11223344, 0});
    tv.push_back('{0, 2'b00, 1, 20'h07FFF, 32'h0, 32'h00000011, 0});
    tv.push_back('{0, 2'b10, 0, OOR, 32'h0, 32'h0, 1});
    tv.push_back('{0, 2'b00, 0, 20'(OOR + 1), 32'h0, 32'h0, 1});

    repeat (3) @(negedge clk);
    check("rst ready", 32'(req_ready), 0);
    check("rst valid", 32'(resp_valid), 0);
    check("rst data", resp_data, 32'h0);
    check("rst err", 32'(resp_err), 0);
    rst = 1'b1;
    #1;
    check("rel ready pre", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("rel ready post", 32'(req_ready), 1);
    @(negedge clk);

    for (int i = 0; i < tv.size(); i++) txn(tv[i], $sformatf("v%0d", i));

    resp_ready = 1'b0;
    v = '{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A87425, 0};
    drive(v);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    check("stall lat", 32'(lat), 32'(L));
    held = sb.size() > 0 ? sb[0].d : 32'hX;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_size   = 2'b10;
      address    = 20'h00018;
      write_data = 32'hDEADBEEF;
      @(posedge clk); #1;
      check("stall valid", 32'(resp_valid), 1);
      check("stall data", resp_data, held);
      check("stall ready", 32'(req_ready), 0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    pop_check("stall");
    @(posedge clk); #1;
    check("stall done", 32'(resp_valid), 0);
    @(negedge clk);
    txn('{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A87425, 0}, "post stall");

    drive('{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A87425, 0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait state", 32'(resp_valid), 0);
    rst = 1'b0;
    #1;
    check("rstw valid", 32'(resp_valid), 0);
    check("rstw ready", 32'(req_ready), 0);
    sb.delete();
    @(posedge clk); #1;
    check("rstw hold", 32'(resp_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    txn('{0, 2'b10, 0, 20'h00018, 32'h0, 32'hB6A87425, 0}, "after rstw");

    resp_ready = 1'b0;
    drive('{1, 2'b10, 0, 20'h00020, 32'h5A5A0F0F, 32'h0, 0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstr valid pre", 32'(resp_valid), 1);
    rst = 1'b0;
    #1;
    check("rstr valid", 32'(resp_valid), 0);
    check("rstr data", resp_data, 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    txn('{0, 2'b10, 0, 20'h00020, 32'h0, 32'h5A5A0F0F, 0}, "after rstr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
